router_reg: RTL and testbench
=============================

Name: router_reg

Overview:
- Input register stage of the router. It sits directly upstream of each output FIFO and drives the FIFO's 8-bit data input.
- Latches the header byte of each packet and forwards header, payload and parity bytes under control of the router FSM's state strobes.
- Holds one byte that arrived while the FIFO was full.
- Computes running XOR parity over header and payload, compares it with the received parity byte, and flags mismatches.

Parameters:
- WIDTH, 8, byte width of data path and parity (header field layout assumes 8).
- BAD_ADDR, 2'b11, header address value that is never latched.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock, synchronous and active-high
- pkt_valid  in  1  source asserts for header and payload bytes; deasserted on the parity byte
- data_in  in  WIDTH  byte from source; header is [7:2]=payload length, [1:0]=dest address
- fifo_full  in  1  full flag of the selected downstream FIFO
- detect_add  in  1  FSM in DECODE_ADDRESS
- lfd_state  in  1  FSM in LOAD_FIRST_DATA
- ld_state  in  1  FSM in LOAD_DATA
- laf_state  in  1  FSM in LOAD_AFTER_FULL
- full_state  in  1  FSM in FIFO_FULL_STATE
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR; clears low_pkt_valid
- dout  out  WIDTH  byte to FIFO din
- err  out  1  parity mismatch for the current packet
- parity_done  out  1  parity byte has been received
- low_pkt_valid  out  1  pkt_valid fell while in LOAD_DATA

Behaviour:
- Reset (rst=1 at clk edge): dout, err, parity_done, low_pkt_valid, header reg, hold byte, internal parity and packet parity all go to 0. Reset takes priority over every other term, including mid-packet.
- Header reg: loads data_in when detect_add && pkt_valid && data_in[1:0]!=BAD_ADDR. Otherwise holds.
- dout: registered, 1-cycle latency, priority order:
  - lfd_state -> header reg
  - ld_state && !fifo_full -> data_in
  - laf_state -> hold byte
  - otherwise hold
- Hold byte: loads data_in when ld_state && fifo_full. It is replayed exactly once via laf_state.
- Internal parity:
  - detect_add -> 0
  - lfd_state -> ^= header reg
  - ld_state && pkt_valid && !full_state -> ^= data_in
  - Parity byte (pkt_valid=0) is never XORed in.
- Packet parity reg: detect_add -> 0; ld_state && !pkt_valid -> data_in.
- low_pkt_valid: rst_int_reg -> 0 (priority); ld_state && !pkt_valid -> 1; otherwise hold.
- parity_done:
  - detect_add -> 0
  - set on (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_pkt_valid && !parity_done)
  - Once set, holds until the next detect_add.
- err:
  - detect_add -> 0
  - When parity_done==1, err <= (internal parity != packet parity); otherwise hold.
  - err therefore becomes valid 1 cycle after parity_done rises and stays stable until the next packet.
- Simultaneous events:
  - detect_add dominates all parity/err/parity_done updates.
  - fifo_full on the parity cycle: the parity byte goes to both the hold byte and the packet parity reg. parity_done is deferred to the laf_state cycle.
- Arithmetic: all XOR is bitwise WIDTH-wide, no carries.
- dout is never driven to Z; it always holds a defined value.

Test Plan:
- rst=1 for 2 cycles with random inputs -> dout=8'h00, err=0, parity_done=0, low_pkt_valid=0.
- Good packet: header 8'h0D (len 3, addr 01) in detect_add; lfd; ld with 8'h11, 8'h22, 8'h33 (pkt_valid=1); ld with parity 8'h0D (pkt_valid=0):
  - dout sequence is 0D, 11, 22, 33 (one cycle after each strobe)
  - parity_done=1 after the parity cycle
  - err=0 next cycle
  - low_pkt_valid=1 until rst_int_reg
- Same packet with parity 8'h0E -> parity_done=1, then err=1. err returns to 0 at the next detect_add.
- fifo_full=1 during ld with data_in=8'h22:
  - dout holds 8'h11 while fifo_full=1
  - the hold byte captures 8'h22
  - the laf_state cycle drives dout=8'h22
  - internal parity excludes bytes presented in full_state
- Header 8'h0F (addr 11) in detect_add -> header reg unchanged (keeps previous 8'h0D); lfd_state outputs 8'h0D.
- rst=1 asserted mid-payload after 8'h11 -> all outputs 0 next cycle. A new packet afterwards computes parity from scratch and gives err=0 for correct parity.

Source files
------------

// File: rtl/router_reg.sv
// router_reg: input register stage ahead of an output FIFO; forwards header/payload/parity bytes,
// holds a byte across FIFO-full, and checks the running XOR parity against the received parity byte.
module router_reg #(
    parameter int         WIDTH    = 8,
    parameter logic [1:0] BAD_ADDR = 2'b11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             err,
    output logic             parity_done,
    output logic             low_pkt_valid
);
    logic [WIDTH-1:0] dout_q, dout_d, header_q, header_d, hold_q, hold_d;
    logic [WIDTH-1:0] int_par_q, int_par_d, pkt_par_q, pkt_par_d;
    logic             err_q, err_d, parity_done_q, parity_done_d, low_pkt_valid_q, low_pkt_valid_d;
    logic             parity_rx, pd_set;

    always_comb begin
        parity_rx       = ld_state && !pkt_valid;
        // a parity byte that met a full FIFO completes only when it is replayed
        pd_set          = (parity_rx && !fifo_full) || (laf_state && low_pkt_valid_q && !parity_done_q);
        header_d        = (detect_add && pkt_valid && data_in[1:0] != BAD_ADDR) ? data_in : header_q;
        dout_d          = lfd_state                ? header_q :
                          (ld_state && !fifo_full) ? data_in  :
                          laf_state                ? hold_q   : dout_q;
        hold_d          = (ld_state && fifo_full) ? data_in : hold_q;
        int_par_d       = detect_add                              ? '0                   :
                          lfd_state                               ? int_par_q ^ header_q :
                          (ld_state && pkt_valid && !full_state)  ? int_par_q ^ data_in  : int_par_q;
        pkt_par_d       = detect_add ? '0 : parity_rx ? data_in : pkt_par_q;
        low_pkt_valid_d = rst_int_reg ? 1'b0 : parity_rx ? 1'b1 : low_pkt_valid_q;
        parity_done_d   = detect_add ? 1'b0 : pd_set ? 1'b1 : parity_done_q;
        err_d           = detect_add ? 1'b0 : parity_done_q ? (int_par_q != pkt_par_q) : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q          <= '0;
            header_q        <= '0;
            hold_q          <= '0;
            int_par_q       <= '0;
            pkt_par_q       <= '0;
            err_q           <= 1'b0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            dout_q          <= dout_d;
            header_q        <= header_d;
            hold_q          <= hold_d;
            int_par_q       <= int_par_d;
            pkt_par_q       <= pkt_par_d;
            err_q           <= err_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    assign dout          = dout_q;
    assign err           = err_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: randomized packet-level stimulus with a scoreboard of expected outputs per cycle.
module tb_router_reg;
    logic       clk = 1'b0, rst, pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
    logic       laf_state, full_state, rst_int_reg, err, parity_done, low_pkt_valid;
    logic [7:0] data_in, dout;

    router_reg dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .dout(dout), .err(err),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int sig; logic [7:0] v; } exp_t;
    exp_t       sb[$];
    exp_t       me;
    logic [7:0] act;
    int         cyc = 0, compared = 0, mismatched = 0;
    logic [7:0] hdr_m = 8'h00, dm = 8'h00;
    logic [7:0] pl[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(int s);
        return s == 0 ? "dout" : s == 1 ? "err" : s == 2 ? "parity_done" : "low_pkt_valid";
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].t <= cyc) begin
            me  = sb.pop_front();
            act = me.sig == 0 ? dout : me.sig == 1 ? {7'd0, err} :
                  me.sig == 2 ? {7'd0, parity_done} : {7'd0, low_pkt_valid};
            compared++;
            if (act !== me.v) begin
                mismatched++;
                $display("FAIL %s cyc=%0d got %h expected %h", sig_name(me.sig), cyc, act, me.v);
            end
        end
    end

    task automatic expect_o(input int sig, input logic [7:0] v);
        sb.push_back('{cyc + 1, sig, v});
    endtask

    task automatic step(input logic r, d, lf, l, la, fs, ri, pv, ff, input logic [7:0] di);
        @(negedge clk);
        rst = r; detect_add = d; lfd_state = lf; ld_state = l; laf_state = la;
        full_state = fs; rst_int_reg = ri; pkt_valid = pv; fifo_full = ff; data_in = di;
    endtask

    // one packet through the strobes an FSM would issue; stall/abort are payload indices or -1
    task automatic pkt(input logic [7:0] hdr, input int stall, input bit par_full, input bit bad,
                       input int abort);
        logic [7:0] par, p, b;
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, hdr);
        if (hdr[1:0] != 2'b11) hdr_m = hdr;
        expect_o(0, dm); expect_o(1, 0); expect_o(2, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 8'($urandom));
        dm = hdr_m; par = hdr_m; expect_o(0, dm);
        for (int i = 0; i < pl.size(); i++) begin
            b = pl[i];
            if (i == abort) begin
                step(1, 0, 0, 1, 0, 0, 0, 1, $urandom_range(0, 1) == 1, b);
                dm = 0; hdr_m = 0;
                expect_o(0, 0); expect_o(1, 0); expect_o(2, 0); expect_o(3, 0);
                return;
            end
            if (i == stall) begin
                step(0, 0, 0, 1, 0, 0, 0, 1, 1, b);
                par ^= b; expect_o(0, dm);
                step(0, 0, 0, 0, 0, 1, 0, 1, 1, 8'($urandom));
                expect_o(0, dm);
                step(0, 0, 0, 0, 1, 0, 0, 1, 0, 8'($urandom));
                dm = b; expect_o(0, dm); expect_o(2, 0);
            end else begin
                step(0, 0, 0, 1, 0, 0, 0, 1, 0, b);
                par ^= b; dm = b; expect_o(0, dm);
            end
        end
        p = bad ? par ^ 8'($urandom_range(1, 255)) : par;
        if (!par_full) begin
            step(0, 0, 0, 1, 0, 0, 0, 0, 0, p);
            dm = p; expect_o(0, dm); expect_o(2, 1); expect_o(3, 1);
        end else begin
            step(0, 0, 0, 1, 0, 0, 0, 0, 1, p);
            expect_o(0, dm); expect_o(2, 0); expect_o(3, 1);
            step(0, 0, 0, 0, 1, 0, 0, 0, 0, 8'($urandom));
            dm = p; expect_o(0, dm); expect_o(2, 1); expect_o(3, 1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'($urandom));
        expect_o(0, dm); expect_o(1, {7'd0, p != par}); expect_o(2, 1); expect_o(3, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'($urandom));
        expect_o(1, {7'd0, p != par}); expect_o(2, 1); expect_o(3, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got timeout expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
        full_state = 0; rst_int_reg = 0; pkt_valid = 0; fifo_full = 0; data_in = 0;
        repeat (2) begin
            step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            expect_o(0, 0); expect_o(1, 0); expect_o(2, 0); expect_o(3, 0);
        end
        pl = '{8'h11, 8'h22, 8'h33};
        pkt(8'h0D, -1, 0, 0, -1);
        pkt(8'h0D, -1, 0, 1, -1);
        pkt(8'h0D, 1, 0, 0, -1);
        pkt(8'h0F, -1, 0, 0, -1);
        pkt(8'h0D, -1, 1, 1, -1);
        pkt(8'h0D, -1, 0, 0, 1);
        pkt(8'h0D, -1, 0, 0, -1);
        repeat (60) begin
            pl = {};
            repeat ($urandom_range(1, 6)) pl.push_back(8'($urandom));
            pkt(8'($urandom), $urandom_range(0, 2) == 0 ? int'($urandom_range(0, pl.size() - 1)) : -1,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 7) == 0 ? int'($urandom_range(0, pl.size() - 1)) : -1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
